deck_shuffler: RTL and testbench

- Downstream consumer of Nxt_Addr.
- Holds the 52-card deck in an internal register array.
- Runs one Fisher-Yates-style swap pass: drives Addr_i into Nxt_Addr, takes back Addr_j, and swaps deck[i] with deck[j] for i = 0..DECK_SIZE-1.
- The dealer FSM reads the shuffled deck through a combinational read port.

---
 rtl/deck_pkg.sv | 18 +
 rtl/deck_shuffler_if.sv | 29 ++
 rtl/deck_regfile.sv | 47 ++++
 rtl/deck_shuffler.sv | 115 +++++++++++
 tb/tb_deck_shuffler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/deck_pkg.sv
// Shared constants and types for the deck shuffler: default sizes, FSM state
// encoding and the card type.
package deck_pkg;

    localparam int DECK_SIZE_DEF = 52;
    localparam int ADDR_W_DEF    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SWAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef logic [ADDR_W_DEF-1:0] card_t;

endpackage

// File: rtl/deck_shuffler_if.sv
// Bundle between the shuffler, its Nxt_Addr partner and the dealer that reads
// the deck. The master modport is the shuffler side.
interface deck_shuffler_if #(
    parameter int ADDR_W = 6
);
    // i_Start is a level sampled on the rising edge while idle. o_Busy is high
    // from the first pass cycle until o_Done, a one-cycle pulse. o_Valid is high
    // whenever no pass is running and o_RdCard may be trusted. During a pass
    // o_AddrI presents the swap index and i_AddrJ must settle within that cycle.
    logic              i_Start;
    logic [ADDR_W-1:0] o_AddrI;
    logic [ADDR_W-1:0] i_AddrJ;
    logic [ADDR_W-1:0] i_RdAddr;
    logic [ADDR_W-1:0] o_RdCard;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Valid;

    modport master (
        input  i_Start, i_AddrJ, i_RdAddr,
        output o_AddrI, o_RdCard, o_Busy, o_Done, o_Valid
    );

    modport slave (
        output i_Start, i_AddrJ, i_RdAddr,
        input  o_AddrI, o_RdCard, o_Busy, o_Done, o_Valid
    );

endinterface

// File: rtl/deck_regfile.sv
// Deck storage: DECK_SIZE cards, reset to the identity order, with a dealer
// read port, a two-entry swap write port and a single-entry init write port.
module deck_regfile
    import deck_pkg::*;
#(
    parameter int DECK_SIZE = DECK_SIZE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [ADDR_W-1:0] rd_card_o,
    input  logic              swap_we_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] data_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [ADDR_W-1:0] data_b_i,
    output logic [ADDR_W-1:0] rd_a_o,
    output logic [ADDR_W-1:0] rd_b_o,
    input  logic              init_we_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [ADDR_W-1:0] init_data_i
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);

    logic [ADDR_W-1:0] mem_q [DECK_SIZE];

    // Out-of-range addresses read as zero so callers never see an undefined entry.
    assign rd_card_o = (rd_addr_i <= LAST) ? mem_q[rd_addr_i] : '0;
    assign rd_a_o    = (addr_a_i  <= LAST) ? mem_q[addr_a_i]  : '0;
    assign rd_b_o    = (addr_b_i  <= LAST) ? mem_q[addr_b_i]  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                mem_q[k] <= ADDR_W'(k);
            end
        end else if (swap_we_i) begin
            mem_q[addr_a_i] <= data_a_i;
            mem_q[addr_b_i] <= data_b_i;
        end else if (init_we_i) begin
            mem_q[init_addr_i] <= init_data_i;
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// One Fisher-Yates-style swap pass over the deck, driven by an external partner
// address source. Define SHUFFLE_RESTORE_EN to restore the identity deck first.
module deck_shuffler
    import deck_pkg::*;
#(
    parameter int DECK_SIZE = DECK_SIZE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic            clk_2K,
    input  logic            i_Reset,
    deck_shuffler_if.master bus,
    output state_e          o_State
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic              swap_we;
    logic              init_we;
    logic [ADDR_W-1:0] rd_a, rd_b;

    // Cross-wired read taps: entry idx receives deck[j] and vice versa.
    deck_regfile #(
        .DECK_SIZE (DECK_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .clk         (clk_2K),
        .rst         (i_Reset),
        .rd_addr_i   (bus.i_RdAddr),
        .rd_card_o   (bus.o_RdCard),
        .swap_we_i   (swap_we),
        .addr_a_i    (idx_q),
        .data_a_i    (rd_b),
        .addr_b_i    (j_q),
        .data_b_i    (rd_a),
        .rd_a_o      (rd_a),
        .rd_b_o      (rd_b),
        .init_we_i   (init_we),
        .init_addr_i (idx_q),
        .init_data_i (idx_q)
    );

    always_ff @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        j_d     = j_q;
        swap_we = 1'b0;
        init_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    idx_d = '0;
`ifdef SHUFFLE_RESTORE_EN
                    state_d = ST_INIT;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef SHUFFLE_RESTORE_EN
            ST_INIT: begin
                init_we = 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
`endif
            ST_FETCH: begin
                j_d     = bus.i_AddrJ;
                state_d = ST_SWAP;
            end
            ST_SWAP: begin
                // A partner outside the deck or equal to idx leaves the deck untouched.
                swap_we = (j_q <= LAST) && (j_q != idx_q);
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_AddrI = (state_q == ST_FETCH || state_q == ST_SWAP) ? idx_q : '0;
    assign bus.o_Busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.o_Done  = (state_q == ST_DONE);
    assign bus.o_Valid = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign o_State     = state_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: table of pass scenarios checked against a queue-fed
// deck model, plus mid-pass reset and back-to-back sequences.
module tb_deck_shuffler;
    import deck_pkg::*;

    localparam int N = DECK_SIZE_DEF;
`ifdef SHUFFLE_RESTORE_EN
    localparam int LAT = 157;
`else
    localparam int LAT = 105;
`endif

    localparam int M_MIRROR = 0;
    localparam int M_OOR    = 1;
    localparam int M_SELF   = 2;
    localparam int M_RAND   = 3;

    typedef struct {
        int mode;
        int repulse_at;
        int ident_chk;  // 0: none, 1: must be identity, 2: must differ from identity
    } pass_vec_t;

    logic   clk_2K = 1'b0;
    logic   i_Reset;
    state_e st;

    deck_shuffler_if bus ();

    deck_shuffler dut (
        .clk_2K  (clk_2K),
        .i_Reset (i_Reset),
        .bus     (bus),
        .o_State (st)
    );

    always #5 clk_2K = ~clk_2K;

    // Nxt_Addr stand-in: partner address is a lookup on the current swap index.
    logic [5:0] jmap [64];
    assign bus.i_AddrJ = jmap[bus.o_AddrI];

    int         checks = 0;
    int         errors = 0;
    int         m_deck [N];
    logic [5:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_map(input int mode);
        for (int a = 0; a < 64; a++) begin
            case (mode)
                M_MIRROR: jmap[a] = (a < N) ? 6'(N - 1 - a) : 6'd0;
                M_OOR:    jmap[a] = 6'd60;
                M_SELF:   jmap[a] = 6'(a);
                default:  jmap[a] = 6'($urandom_range(0, 63));
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_deck[k] = k;
    endtask

    task automatic model_pass();
        int j, t;
`ifdef SHUFFLE_RESTORE_EN
        model_reset();
`endif
        for (int i = 0; i < N; i++) begin
            j = int'(jmap[i]);
            if (j < N && j != i) begin
                t = m_deck[i];
                m_deck[i] = m_deck[j];
                m_deck[j] = t;
            end
        end
    endtask

    task automatic check_deck(input string name);
        logic [5:0] e;
        for (int k = 0; k < N; k++) exp_q.push_back(6'(m_deck[k]));
        for (int k = 0; k < N; k++) begin
            bus.i_RdAddr = 6'(k);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s card[%0d]", name, k), int'(bus.o_RdCard), int'(e));
        end
    endtask

    task automatic check_perm_and_ident(input string name, input int ident_chk);
        int seen [N];
        int perm_ok, is_ident;
        perm_ok  = 1;
        is_ident = 1;
        for (int k = 0; k < N; k++) seen[k] = 0;
        for (int k = 0; k < N; k++) begin
            bus.i_RdAddr = 6'(k);
            #1;
            if (int'(bus.o_RdCard) < N) seen[int'(bus.o_RdCard)]++;
            if (int'(bus.o_RdCard) != k) is_ident = 0;
        end
        for (int k = 0; k < N; k++) if (seen[k] != 1) perm_ok = 0;
        check({name, " permutation"}, perm_ok, 1);
        if (ident_chk == 1) check({name, " identity"}, is_ident, 1);
        if (ident_chk == 2) check({name, " differs"}, is_ident, 0);
    endtask

    task automatic run_pass(input string name, input int repulse_at);
        int n, lat, dones, sweep_ok;
        int fetch_q [$];
        lat   = -1;
        dones = 0;
        @(negedge clk_2K);
        bus.i_Start = 1'b1;
        @(posedge clk_2K);
        #1 bus.i_Start = 1'b0;
        n = 0;
        while (n < LAT + 60) begin
            @(negedge clk_2K);
            n++;
            if (n == repulse_at) bus.i_Start = 1'b1;
            if (n == repulse_at + 1) bus.i_Start = 1'b0;
            if (n == 1) begin
                check({name, " busy at T+1"}, int'(bus.o_Busy), 1);
                check({name, " valid at T+1"}, int'(bus.o_Valid), 0);
            end
            if (st == ST_FETCH) fetch_q.push_back(int'(bus.o_AddrI));
            if (bus.o_Done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    check({name, " busy at done"}, int'(bus.o_Busy), 0);
                    check({name, " valid at done"}, int'(bus.o_Valid), 1);
                    check({name, " addr at done"}, int'(bus.o_AddrI), 0);
                end
            end
        end
        check({name, " done latency"}, lat, LAT);
        check({name, " done count"}, dones, 1);
        check({name, " idle after"}, int'(st), int'(ST_IDLE));
        sweep_ok = (fetch_q.size() == N) ? 1 : 0;
        for (int k = 0; k < fetch_q.size() && k < N; k++) if (fetch_q[k] != k) sweep_ok = 0;
        check({name, " addr sweep"}, sweep_ok, 1);
    endtask

    pass_vec_t vecs [6];

    initial begin
        int n, dones, d1, d2;

        vecs[0] = '{M_MIRROR, 0,  1};
        vecs[1] = '{M_OOR,    0,  1};
        vecs[2] = '{M_SELF,   0,  1};
        vecs[3] = '{M_RAND,   0,  2};
        vecs[4] = '{M_RAND,   0,  2};
        vecs[5] = '{M_MIRROR, 20, 0};

        i_Reset      = 1'b1;
        bus.i_Start  = 1'b0;
        bus.i_RdAddr = '0;
        set_map(M_MIRROR);
        model_reset();
        #12;
        check("reset busy", int'(bus.o_Busy), 0);
        check("reset done", int'(bus.o_Done), 0);
        check("reset valid", int'(bus.o_Valid), 1);
        check("reset addr", int'(bus.o_AddrI), 0);
        check("reset state", int'(st), int'(ST_IDLE));
        @(negedge clk_2K);
        i_Reset = 1'b0;
        check_deck("reset");
        for (int k = N; k < 64; k++) begin
            bus.i_RdAddr = 6'(k);
            #1;
            check($sformatf("oor read %0d", k), int'(bus.o_RdCard), 0);
        end

        for (int v = 0; v < 6; v++) begin
            set_map(vecs[v].mode);
            run_pass($sformatf("pass%0d", v), vecs[v].repulse_at);
            model_pass();
            check_deck($sformatf("pass%0d", v));
            check_perm_and_ident($sformatf("pass%0d", v), vecs[v].ident_chk);
        end

        // Reset in the middle of a random pass.
        set_map(M_RAND);
        @(negedge clk_2K);
        bus.i_Start = 1'b1;
        @(posedge clk_2K);
        #1 bus.i_Start = 1'b0;
        repeat (40) @(negedge clk_2K);
        check("midrst busy before", int'(bus.o_Busy), 1);
        i_Reset = 1'b1;
        #1;
        check("midrst busy", int'(bus.o_Busy), 0);
        check("midrst done", int'(bus.o_Done), 0);
        check("midrst valid", int'(bus.o_Valid), 1);
        check("midrst addr", int'(bus.o_AddrI), 0);
        check("midrst state", int'(st), int'(ST_IDLE));
        model_reset();
        check_deck("midrst");
        @(negedge clk_2K);
        i_Reset = 1'b0;
        dones = 0;
        repeat (LAT + 20) begin
            @(negedge clk_2K);
            if (bus.o_Done) dones++;
        end
        check("midrst no done", dones, 0);

        // Start held high through DONE: second pass follows from IDLE.
        set_map(M_MIRROR);
        @(negedge clk_2K);
        bus.i_Start = 1'b1;
        n  = 0;
        d1 = -1;
        d2 = -1;
        while (n < 2 * LAT + 20 && d2 < 0) begin
            @(negedge clk_2K);
            n++;
            if (bus.o_Done) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
        end
        bus.i_Start = 1'b0;
        check("b2b first done", d1, LAT);
        check("b2b second done", d2, 2 * LAT + 1);
        repeat (4) @(negedge clk_2K);
        check("b2b idle", int'(st), int'(ST_IDLE));
        model_pass();
        model_pass();
        check_deck("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
